dft_bin_scan_ctrl: RTL and testbench
====================================

# dft_bin_scan_ctrl

Scheduler that time-shares one single-bin DFT engine across a list of bins. It captures an N-sample real frame into a local buffer, then for each requested bin resets the engine, loads the bin index, replays the frame into it, and collects the result. Each result is presented on a valid/ready output stream. It sits between the sample source and the downstream spectral consumer, upstream of the runtime-K single-bin engine.

## Interface
- N, 1024: frame length in samples; power of two, ≥ 4.
- DW, 16: sample width, signed two's complement.
- RW, 40: engine result width per component, signed.
- MAXB, 16: maximum bins per frame.
- KW, $clog2(N): bin index width (derived).
- BW, $clog2(MAXB+1): bin count width (derived).

Ports:
- clk  in  1  sole clock; all logic on rising edge.
- rst  in  1  reset, synchronous, active-high.
- s_valid  in  1  input sample valid.
- s_ready  out  1  high only in CAPTURE.
- s_data  in  DW  input sample.
- cfg_k0  in  KW  first bin index; latched at frame end.
- cfg_kstep  in  KW  bin increment; latched at frame end.
- cfg_nbins  in  BW  bins per frame; latched at frame end; 0 treated as 1; values > MAXB clamp to MAXB.
- eng_rst  out  1  engine block restart.
- eng_k  out  KW  engine bin index; stable from ARM through WAIT.
- eng_valid  out  1  engine sample strobe.
- eng_x  out  DW  engine sample.
- eng_done  in  1  engine result ready; held until the next eng_rst.
- eng_re, eng_im  in  RW  engine result.
- m_valid  out  1  result valid.
- m_ready  in  1  consumer accept.
- m_k  out  KW  bin index of the result.
- m_re, m_im  out  RW  result.
- m_last  out  1  last bin of the frame.
- busy  out  1  high in every state except CAPTURE.

## Operation
- States: CAPTURE, ARM, FEED, WAIT, OUT.
- CAPTURE: each s_valid&&s_ready beat writes buf[wr_idx] and increments wr_idx.
  - When the beat with wr_idx = N-1 is accepted: latch cfg, set bin_idx=0, set k=cfg_k0, go to ARM.
- ARM: eng_rst=1 for exactly one cycle with eng_k=k; read address=0 issued. Go to FEED.
- FEED: eng_valid=1 for exactly N consecutive cycles, carrying buf[0..N-1] in order.
  - Buffer read is 1-cycle synchronous (block RAM inferable).
  - After the N-th strobe, go to WAIT.
- WAIT: on eng_done=1, register eng_re/eng_im into m_re/m_im, set m_k=k, and set m_last=(bin_idx==nbins-1). Go to OUT.
- OUT: m_valid=1, payload stable until m_ready. On handshake:
  - if m_last, go to CAPTURE with wr_idx=0;
  - else bin_idx+1, k=(k+kstep) mod N (KW-bit wrap), go to ARM.
- No samples are accepted outside CAPTURE (s_ready=0 applies backpressure; no drops).
- rst at any time returns to CAPTURE with wr_idx=0. Any partial frame or pending result is discarded.

## Timing
- Reset values: s_ready=1 (CAPTURE; asserted in the cycle after rst deasserts), eng_rst=1 while rst is high and 0 after, eng_valid=0, eng_k=0, eng_x=0, m_valid=0, m_k=0, m_re=0, m_im=0, m_last=0, busy=0.
- Last capture beat at cycle t: ARM at t+1, eng_valid cycles t+2..t+N+1.
- The engine raises eng_done one cycle after its N-th strobe. WAIT therefore lasts 1 cycle nominally, and m_valid rises at t+N+3.
- Per-bin cost with m_ready held high: N+3 cycles (ARM 1, FEED N, WAIT 1, OUT 1).
- Frame cost: N capture cycles (minimum) plus nbins·(N+3).
- eng_done sampled in any state other than WAIT is ignored.
- m_valid must not drop and payload must not change while m_ready=0.

## Test plan
- N=16, k0=3, kstep=0, nbins=1, cosine at bin 3, amplitude 1000, m_ready=1 → one result with m_k=3, m_last=1, |m_re| ≈ 8000 ± 1 LSB, m_im ≈ 0; s_ready returns 1 cycle after handshake.
- N=16, k0=14, kstep=1, nbins=4 → m_k sequence 14, 15, 0, 1; m_last only on 1; eng_rst pulses exactly 4 times, 1 cycle each; 16 eng_valid cycles per bin, each in buffer order.
- m_ready low for 7 cycles during OUT → m_valid/m_k/m_re/m_im held constant; no eng_rst until handshake.
- s_valid toggled randomly during CAPTURE and held high throughout busy → exactly N samples captured per frame; s_ready=0 whenever busy=1; second frame's results match its own data.
- rst asserted mid-FEED (bin 2 of 4) → next cycle after rst: eng_valid=0, m_valid=0, busy=0; the next full frame yields a full 4-result sequence starting at k0.
- cfg_nbins=0 and cfg_nbins=MAXB+3 → 1 result and MAXB results respectively; cfg changes during busy do not affect the current frame.

Source files
------------

// File: rtl/dft_bin_scan_ctrl_if.sv
// rtl/dft_bin_scan_ctrl_if.sv - sample, engine and result signal bundle for dft_bin_scan_ctrl
interface dft_bin_scan_ctrl_if #(
  parameter int DW = 16,
  parameter int KW = 10,
  parameter int RW = 40
);
  // sample stream into the frame buffer
  logic                 s_valid;
  logic                 s_ready;
  logic signed [DW-1:0] s_data;

  // single-bin engine side
  logic                 eng_rst;
  logic        [KW-1:0] eng_k;
  logic                 eng_valid;
  logic signed [DW-1:0] eng_x;
  logic                 eng_done;
  logic signed [RW-1:0] eng_re;
  logic signed [RW-1:0] eng_im;

  // result stream to the spectral consumer
  logic                 m_valid;
  logic                 m_ready;
  logic        [KW-1:0] m_k;
  logic signed [RW-1:0] m_re;
  logic signed [RW-1:0] m_im;
  logic                 m_last;

  modport master (
    input  s_valid, s_data, eng_done, eng_re, eng_im, m_ready,
    output s_ready, eng_rst, eng_k, eng_valid, eng_x,
           m_valid, m_k, m_re, m_im, m_last
  );

  modport slave (
    output s_valid, s_data, eng_done, eng_re, eng_im, m_ready,
    input  s_ready, eng_rst, eng_k, eng_valid, eng_x,
           m_valid, m_k, m_re, m_im, m_last
  );
endinterface

// File: rtl/dft_bin_scan_ctrl.sv
// rtl/dft_bin_scan_ctrl.sv - captures a frame and replays it through one DFT engine per requested bin
module dft_bin_scan_ctrl #(
  parameter int N    = 1024,
  parameter int DW   = 16,
  parameter int RW   = 40,
  parameter int MAXB = 16,
  parameter int KW   = $clog2(N),
  parameter int BW   = $clog2(MAXB + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  dft_bin_scan_ctrl_if.master   bus,
  input  logic [KW-1:0]         cfg_k0,
  input  logic [KW-1:0]         cfg_kstep,
  input  logic [BW-1:0]         cfg_nbins,
  output logic                  busy
);

  typedef enum logic [2:0] {S_CAPTURE, S_ARM, S_FEED, S_WAIT, S_OUT} state_t;

  state_t               state_q, state_d;
  logic        [KW-1:0] wr_idx_q, wr_idx_d;
  logic        [KW-1:0] cnt_q, cnt_d;
  logic        [KW-1:0] k_q, k_d;
  logic        [KW-1:0] kstep_q, kstep_d;
  logic        [BW-1:0] nbins_q, nbins_d;
  logic        [BW-1:0] bin_idx_q, bin_idx_d;
  logic        [KW-1:0] m_k_q, m_k_d;
  logic signed [RW-1:0] m_re_q, m_re_d;
  logic signed [RW-1:0] m_im_q, m_im_d;
  logic                 m_last_q, m_last_d;

  logic signed [DW-1:0] frame_mem [N];
  logic signed [DW-1:0] rd_data_q;
  logic        [KW-1:0] rd_addr;
  logic                 wr_en;
  logic        [BW-1:0] nbins_clamped;

  // Bin count as it will be used: zero means one bin, oversize saturates at MAXB
  always_comb begin
    nbins_clamped = cfg_nbins;
    if (cfg_nbins == '0) begin
      nbins_clamped = BW'(1);
    end else if (cfg_nbins > BW'(MAXB)) begin
      nbins_clamped = BW'(MAXB);
    end
  end

  // Frame buffer: capture write port plus a registered read port that runs one address ahead of FEED
  always_ff @(posedge clk) begin
    if (wr_en) begin
      frame_mem[wr_idx_q] <= bus.s_data;
    end
    rd_data_q <= frame_mem[rd_addr];
  end

  // Next-state logic for capture, per-bin replay and result hand-off
  always_comb begin
    state_d   = state_q;
    wr_idx_d  = wr_idx_q;
    cnt_d     = cnt_q;
    k_d       = k_q;
    kstep_d   = kstep_q;
    nbins_d   = nbins_q;
    bin_idx_d = bin_idx_q;
    m_k_d     = m_k_q;
    m_re_d    = m_re_q;
    m_im_d    = m_im_q;
    m_last_d  = m_last_q;
    rd_addr   = '0;
    wr_en     = 1'b0;
    case (state_q)
      S_CAPTURE: begin
        if (bus.s_valid) begin
          wr_en    = 1'b1;
          wr_idx_d = wr_idx_q + KW'(1);
          if (wr_idx_q == KW'(N - 1)) begin
            k_d       = cfg_k0;
            kstep_d   = cfg_kstep;
            nbins_d   = nbins_clamped;
            bin_idx_d = '0;
            state_d   = S_ARM;
          end
        end
      end
      S_ARM: begin
        rd_addr = '0;
        cnt_d   = '0;
        state_d = S_FEED;
      end
      S_FEED: begin
        // the address past the last sample wraps to 0 and is simply never used
        rd_addr = cnt_q + KW'(1);
        cnt_d   = cnt_q + KW'(1);
        if (cnt_q == KW'(N - 1)) begin
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (bus.eng_done) begin
          m_re_d   = bus.eng_re;
          m_im_d   = bus.eng_im;
          m_k_d    = k_q;
          m_last_d = (bin_idx_q == nbins_q - BW'(1));
          state_d  = S_OUT;
        end
      end
      S_OUT: begin
        if (bus.m_ready) begin
          if (m_last_q) begin
            wr_idx_d = '0;
            state_d  = S_CAPTURE;
          end else begin
            bin_idx_d = bin_idx_q + BW'(1);
            k_d       = k_q + kstep_q;
            state_d   = S_ARM;
          end
        end
      end
      default: begin
        wr_idx_d = '0;
        state_d  = S_CAPTURE;
      end
    endcase
  end

  // State and datapath registers; reset drops any partial frame or pending result
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_CAPTURE;
      wr_idx_q  <= '0;
      cnt_q     <= '0;
      k_q       <= '0;
      kstep_q   <= '0;
      nbins_q   <= BW'(1);
      bin_idx_q <= '0;
      m_k_q     <= '0;
      m_re_q    <= '0;
      m_im_q    <= '0;
      m_last_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      wr_idx_q  <= wr_idx_d;
      cnt_q     <= cnt_d;
      k_q       <= k_d;
      kstep_q   <= kstep_d;
      nbins_q   <= nbins_d;
      bin_idx_q <= bin_idx_d;
      m_k_q     <= m_k_d;
      m_re_q    <= m_re_d;
      m_im_q    <= m_im_d;
      m_last_q  <= m_last_d;
    end
  end

  assign bus.s_ready   = (state_q == S_CAPTURE);
  assign busy          = (state_q != S_CAPTURE);
  assign bus.eng_rst   = rst || (state_q == S_ARM);
  assign bus.eng_k     = k_q;
  assign bus.eng_valid = (state_q == S_FEED);
  assign bus.eng_x     = (state_q == S_FEED) ? rd_data_q : '0;
  assign bus.m_valid   = (state_q == S_OUT);
  assign bus.m_k       = m_k_q;
  assign bus.m_re      = m_re_q;
  assign bus.m_im      = m_im_q;
  assign bus.m_last    = m_last_q;

endmodule

// File: tb/tb_dft_bin_scan_ctrl.sv
// tb/tb_dft_bin_scan_ctrl.sv - scoreboard bench for dft_bin_scan_ctrl with a behavioural single-bin engine
module tb_dft_bin_scan_ctrl;
  localparam int  N    = 16;
  localparam int  DW   = 16;
  localparam int  RW   = 40;
  localparam int  MAXB = 16;
  localparam int  KW   = $clog2(N);
  localparam int  BW   = $clog2(MAXB + 1);
  localparam real PI   = 3.14159265358979;

  typedef logic signed [DW-1:0] frame_t [N];
  typedef struct {
    logic        [KW-1:0] k;
    logic signed [RW-1:0] re;
    logic signed [RW-1:0] im;
    logic                 last;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst;
  logic [KW-1:0] cfg_k0;
  logic [KW-1:0] cfg_kstep;
  logic [BW-1:0] cfg_nbins;
  logic          busy;

  int     cyc = 0;
  int     total = 0;
  int     bad = 0;
  int     popped = 0;
  int     rst_pulses = 0;
  int     valid_cycles = 0;
  int     e_cnt = 0;
  logic [KW-1:0] e_k = '0;
  frame_t e_rx;
  exp_t   sb [$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  dft_bin_scan_ctrl_if #(.DW(DW), .KW(KW), .RW(RW)) bus ();

  dft_bin_scan_ctrl #(.N(N), .DW(DW), .RW(RW), .MAXB(MAXB)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .cfg_k0    (cfg_k0),
    .cfg_kstep (cfg_kstep),
    .cfg_nbins (cfg_nbins),
    .busy      (busy)
  );

  function automatic longint dft(input frame_t x, input int k, input bit want_im);
    real acc;
    real ang;
    acc = 0.0;
    for (int n = 0; n < N; n++) begin
      ang = 2.0 * PI * real'(k * n) / real'(N);
      if (want_im) acc = acc - real'(x[n]) * $sin(ang);
      else         acc = acc + real'(x[n]) * $cos(ang);
    end
    return longint'(acc);
  endfunction

  function automatic frame_t rand_frame();
    frame_t f;
    for (int n = 0; n < N; n++) f[n] = DW'($urandom_range(0, 65535));
    return f;
  endfunction

  // engine model: restart on eng_rst, collect strobes, result ready once N samples are in
  always @(posedge clk) begin
    if (bus.eng_rst) begin
      e_cnt <= 0;
      e_k   <= bus.eng_k;
      if (!rst) rst_pulses <= rst_pulses + 1;
    end else if (bus.eng_valid) begin
      if (e_cnt < N) e_rx[e_cnt] <= bus.eng_x;
      e_cnt        <= e_cnt + 1;
      valid_cycles <= valid_cycles + 1;
    end
  end
  assign bus.eng_done = (e_cnt == N);
  always_comb begin
    bus.eng_re = RW'(dft(e_rx, int'(e_k), 1'b0));
    bus.eng_im = RW'(dft(e_rx, int'(e_k), 1'b1));
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, $signed(obs), $signed(exp));
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_cfg(input int k0, input int ks, input int nb);
    cfg_k0    = KW'(k0);
    cfg_kstep = KW'(ks);
    cfg_nbins = BW'(nb);
  endtask

  task automatic push_exp(input frame_t f, input int k0, input int ks, input int nb_cfg);
    int   nb;
    int   kk;
    exp_t e;
    nb = (nb_cfg == 0) ? 1 : ((nb_cfg > MAXB) ? MAXB : nb_cfg);
    for (int b = 0; b < nb; b++) begin
      kk     = (k0 + b * ks) % N;
      e.k    = KW'(kk);
      e.re   = RW'(dft(f, kk, 1'b0));
      e.im   = RW'(dft(f, kk, 1'b1));
      e.last = (b == nb - 1);
      sb.push_back(e);
    end
  endtask

  task automatic send_frame(input frame_t f, input bit rnd, output int last_cyc);
    int i;
    int guard;
    bit acc;
    i = 0;
    guard = 0;
    last_cyc = 0;
    while (i < N && guard < 2000) begin
      bus.s_valid = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      bus.s_data  = f[i];
      acc = bus.s_valid && bus.s_ready;
      if (acc) last_cyc = cyc;
      tick();
      if (acc) i++;
      guard++;
    end
    chk("frame_sent", 64'(i), 64'(N));
    bus.s_valid = 1'b0;
  endtask

  task automatic wait_pop(input int target, input int budget);
    int n;
    n = 0;
    while (popped < target && n < budget) begin
      tick();
      n++;
    end
    chk("results_arrived", 64'(popped >= target), 64'(1));
  endtask

  // result monitor: scoreboard pop on handshake, payload hold under backpressure, no s_ready while busy
  initial begin
    logic                 hv;
    logic        [KW-1:0] hk;
    logic signed [RW-1:0] hre;
    logic signed [RW-1:0] him;
    exp_t                 e;
    hv = 1'b0;
    hk = '0;
    hre = '0;
    him = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        hv = 1'b0;
      end else begin
        if (busy) chk("s_ready_while_busy", bus.s_ready, 0);
        if (hv) begin
          chk("hold_valid", bus.m_valid, 1);
          chk("hold_k", bus.m_k, hk);
          chk("hold_re", bus.m_re, hre);
          chk("hold_im", bus.m_im, him);
        end
        if (bus.m_valid && bus.m_ready) begin
          chk("result_expected", 64'(sb.size() != 0), 64'(1));
          if (sb.size() != 0) begin
            e = sb.pop_front();
            chk("res_k", bus.m_k, e.k);
            chk("res_re", bus.m_re, e.re);
            chk("res_im", bus.m_im, e.im);
            chk("res_last", bus.m_last, e.last);
          end
          popped++;
        end
        hv  = bus.m_valid && !bus.m_ready;
        hk  = bus.m_k;
        hre = bus.m_re;
        him = bus.m_im;
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    frame_t fa;
    frame_t fb;
    int     lc;
    int     n;
    int     rp0;
    int     vc0;
    int     base;

    rst = 1'b1;
    bus.s_valid = 1'b0;
    bus.s_data  = '0;
    bus.m_ready = 1'b1;
    set_cfg(0, 0, 0);
    repeat (3) tick();
    chk("rst_eng_rst", bus.eng_rst, 1);
    chk("rst_eng_valid", bus.eng_valid, 0);
    chk("rst_eng_k", bus.eng_k, 0);
    chk("rst_eng_x", bus.eng_x, 0);
    chk("rst_m_valid", bus.m_valid, 0);
    chk("rst_m_k", bus.m_k, 0);
    chk("rst_m_re", bus.m_re, 0);
    chk("rst_m_im", bus.m_im, 0);
    chk("rst_m_last", bus.m_last, 0);
    chk("rst_busy", busy, 0);
    rst = 1'b0;
    tick();
    chk("ready_after_rst", bus.s_ready, 1);
    chk("eng_rst_after_rst", bus.eng_rst, 0);

    // cosine at bin 3, amplitude 1000: expect ~N/2*1000 real, ~0 imaginary
    for (int i = 0; i < N; i++) fa[i] = DW'(longint'(1000.0 * $cos(2.0 * PI * 3.0 * real'(i) / real'(N))));
    set_cfg(3, 0, 1);
    base = popped;
    push_exp(fa, 3, 0, 1);
    send_frame(fa, 1'b0, lc);
    n = 0;
    while (!bus.m_valid && n < 200) begin
      tick();
      n++;
    end
    chk("cos_latency", 64'(cyc - lc), 64'(N + 3));
    chk("cos_k", bus.m_k, 3);
    chk("cos_last", bus.m_last, 1);
    chk("cos_re_near_8000", 64'(bus.m_re >= 7999 && bus.m_re <= 8001), 64'(1));
    chk("cos_im_near_0", 64'(bus.m_im >= -1 && bus.m_im <= 1), 64'(1));
    wait_pop(base + 1, 50);
    chk("ready_after_handshake", bus.s_ready, 1);

    // k wraps 14,15,0,1; one eng_rst cycle and N strobes per bin
    fa = rand_frame();
    set_cfg(14, 1, 4);
    rp0 = rst_pulses;
    vc0 = valid_cycles;
    base = popped;
    push_exp(fa, 14, 1, 4);
    send_frame(fa, 1'b0, lc);
    wait_pop(base + 4, 300);
    chk("wrap_eng_rst_cycles", 64'(rst_pulses - rp0), 64'(4));
    chk("wrap_strobes", 64'(valid_cycles - vc0), 64'(4 * N));
    chk("wrap_sb_empty", 64'(sb.size()), 64'(0));

    // backpressure: result held, no new engine restart until handshake
    fa = rand_frame();
    set_cfg(5, 7, 2);
    base = popped;
    push_exp(fa, 5, 7, 2);
    bus.m_ready = 1'b0;
    send_frame(fa, 1'b0, lc);
    n = 0;
    while (!bus.m_valid && n < 200) begin
      tick();
      n++;
    end
    chk("bp_valid_seen", bus.m_valid, 1);
    rp0 = rst_pulses;
    repeat (7) tick();
    chk("bp_no_eng_rst", 64'(rst_pulses - rp0), 64'(0));
    chk("bp_no_pop", 64'(popped - base), 64'(0));
    bus.m_ready = 1'b1;
    wait_pop(base + 2, 200);
    chk("bp_sb_empty", 64'(sb.size()), 64'(0));

    // random s_valid, then s_valid held high (next frame's first sample) throughout busy
    fa = rand_frame();
    fb = rand_frame();
    set_cfg(9, 2, 2);
    base = popped;
    push_exp(fa, 9, 2, 2);
    send_frame(fa, 1'b1, lc);
    bus.s_valid = 1'b1;
    bus.s_data  = fb[0];
    wait_pop(base + 2, 200);
    set_cfg(0, 3, 1);
    push_exp(fb, 0, 3, 1);
    send_frame(fb, 1'b1, lc);
    wait_pop(base + 3, 200);
    chk("tog_sb_empty", 64'(sb.size()), 64'(0));

    // reset while feeding bin 2 of 4, then a full clean frame
    fa = rand_frame();
    set_cfg(2, 5, 4);
    base = popped;
    push_exp(fa, 2, 5, 4);
    send_frame(fa, 1'b0, lc);
    wait_pop(base + 2, 200);
    n = 0;
    while (!bus.eng_valid && n < 50) begin
      tick();
      n++;
    end
    chk("mid_feed_reached", bus.eng_valid, 1);
    repeat (5) tick();
    rst = 1'b1;
    tick();
    chk("midrst_eng_valid", bus.eng_valid, 0);
    chk("midrst_m_valid", bus.m_valid, 0);
    chk("midrst_busy", busy, 0);
    rst = 1'b0;
    sb.delete();
    tick();
    fb = rand_frame();
    base = popped;
    push_exp(fb, 2, 5, 4);
    send_frame(fb, 1'b0, lc);
    wait_pop(base + 4, 300);
    chk("midrst_sb_empty", 64'(sb.size()), 64'(0));

    // nbins=0 gives one bin; cfg changed while busy must not matter
    fa = rand_frame();
    set_cfg(7, 1, 0);
    base = popped;
    push_exp(fa, 7, 1, 0);
    send_frame(fa, 1'b0, lc);
    set_cfg(1, 4, 5);
    wait_pop(base + 1, 100);
    repeat (3) tick();
    chk("nb0_count", 64'(popped - base), 64'(1));
    chk("nb0_sb_empty", 64'(sb.size()), 64'(0));

    // nbins above MAXB saturates at MAXB
    fb = rand_frame();
    set_cfg(1, 3, MAXB + 3);
    base = popped;
    push_exp(fb, 1, 3, MAXB + 3);
    send_frame(fb, 1'b0, lc);
    set_cfg(4, 9, 2);
    wait_pop(base + MAXB, 800);
    repeat (3) tick();
    chk("nbmax_count", 64'(popped - base), 64'(MAXB));
    chk("nbmax_sb_empty", 64'(sb.size()), 64'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
